// File: rtl/burst_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | burst_mem_responder: bmem responder with a line array, 4-beat write      |
// | bursts and a queued, fixed-latency 4-beat read return path.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module burst_mem_responder #(
  parameter int LINES   = 16,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);

  localparam int           IDXW        = $clog2(LINES);
  localparam int           QAW         = $clog2(QDEPTH);
  localparam logic [3:0]   WAIT_CYCLES = 4'(LATENCY - 2);
  localparam logic [QAW:0] QFULL       = (QAW + 1)'(QDEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W1 = 2'd1, W2 = 2'd2, W3 = 2'd3} wstate_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} rstate_e;

  wstate_e         w_state_q;
  logic [IDXW-1:0] w_idx_q;
  logic            err_q;
  logic            alive_q;

  rstate_e         r_state_q;
  logic [3:0]      wait_q;
  logic [1:0]      beat_q;
  logic [31:0]     raddr_q;

  logic [31:0]     q_mem_q [QDEPTH];
  logic [QAW-1:0]  q_wr_q;
  logic [QAW-1:0]  q_rd_q;
  logic [QAW:0]    q_cnt_q;

  logic [63:0]     mem_q [LINES*4];

  logic            w_accept;
  logic            w_cont;
  logic            r_push;
  logic            r_pop;
  logic            err_d;
  logic            mem_we;
  logic [IDXW+1:0] mem_waddr;
  logic [IDXW+1:0] mem_raddr;

  assign bmem_ready  = alive_q && (q_cnt_q < QFULL) && (w_state_q == W_IDLE);
  assign w_accept    = bmem_write & bmem_ready;
  assign w_cont      = (w_state_q != W_IDLE) & bmem_write;
  // A write wins over a simultaneous read; the read is simply not queued.
  assign r_push      = bmem_read & ~bmem_write & bmem_ready;
  assign r_pop       = (r_state_q == R_IDLE) && (q_cnt_q != '0);
  assign err_d       = (bmem_read & bmem_write & bmem_ready)
                     | ((w_state_q != W_IDLE) & ~bmem_write);

  // The write FSM state doubles as the beat number of the incoming word.
  assign mem_we      = w_accept | w_cont;
  assign mem_waddr   = w_accept ? {bmem_addr[5 +: IDXW], 2'd0} : {w_idx_q, w_state_q};
  assign mem_raddr   = {raddr_q[5 +: IDXW], beat_q};

  assign bmem_rvalid = (r_state_q == R_BURST);
  assign bmem_rdata  = bmem_rvalid ? mem_q[mem_raddr] : '0;
  assign bmem_raddr  = raddr_q;
  assign proto_err   = err_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= bmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (r_push) q_mem_q[q_wr_q] <= bmem_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      err_q     <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      err_q   <= err_d;
      case (w_state_q)
        W_IDLE: if (w_accept) begin
          w_idx_q   <= bmem_addr[5 +: IDXW];
          w_state_q <= W1;
        end
        W1:      w_state_q <= bmem_write ? W2 : W_IDLE;
        W2:      w_state_q <= bmem_write ? W3 : W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
    end else begin
      if (r_push) q_wr_q <= q_wr_q + 1'b1;
      if (r_pop)  q_rd_q <= q_rd_q + 1'b1;
      case ({r_push, r_pop})
        2'b10:   q_cnt_q <= q_cnt_q + 1'b1;
        2'b01:   q_cnt_q <= q_cnt_q - 1'b1;
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

  // The pop cycle counts as the first latency cycle, so WAIT holds LATENCY-2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      wait_q    <= '0;
      beat_q    <= '0;
      raddr_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (r_pop) begin
          raddr_q <= q_mem_q[q_rd_q] & 32'hFFFF_FFE0;
          beat_q  <= '0;
          if (WAIT_CYCLES == 4'd0) begin
            r_state_q <= R_BURST;
          end else begin
            wait_q    <= WAIT_CYCLES;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (wait_q == 4'd1) r_state_q <= R_BURST;
          else                wait_q    <= wait_q - 4'd1;
        end
        R_BURST: begin
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_burst_mem_responder: self-checking bench with a cycle-level model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_burst_mem_responder;

  localparam int LINES = 16;
  localparam int LAT   = 4;
  localparam int QD    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  burst_mem_responder #(.LINES(LINES), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 5) % LINES);
  endfunction

  // ---------------- reference model + compare process ----------------
  typedef struct {
    int          acc;
    int          pop;
    int          start;
    logic [31:0] addr;
  } rd_t;

  rd_t         sched[$];
  logic [63:0] mm [LINES*4];
  int          cyc = 0;
  int          last_b3 = -1000;
  int          wst = 0;
  int          widx = 0;
  bit          alive = 0;
  bit          err_exp = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ready", 64'(bmem_ready), 64'd0);
      chk("rst_rvalid", 64'(bmem_rvalid), 64'd0);
      chk("rst_rdata", bmem_rdata, 64'd0);
      chk("rst_raddr", 64'(bmem_raddr), 64'd0);
      chk("rst_err", 64'(proto_err), 64'd0);
      sched.delete();
      last_b3 = -1000;
      wst     = 0;
      alive   = 0;
      err_exp = 0;
    end else begin
      int cnt;
      bit exp_ready;
      bit exp_valid;
      bit err_next;
      while (sched.size() > 0 && sched[0].start + 3 < cyc) void'(sched.pop_front());
      exp_valid = (sched.size() > 0) && (sched[0].start <= cyc);
      cnt = 0;
      foreach (sched[i]) if (sched[i].acc < cyc && cyc <= sched[i].pop) cnt++;
      exp_ready = alive && (cnt < QD) && (wst == 0);

      chk("ready", 64'(bmem_ready), 64'(exp_ready));
      chk("rvalid", 64'(bmem_rvalid), 64'(exp_valid));
      chk("proto_err", 64'(proto_err), 64'(err_exp));
      if (exp_valid) begin
        chk("raddr", 64'(bmem_raddr), 64'(sched[0].addr & 32'hFFFF_FFE0));
        chk("rdata", bmem_rdata, mm[midx(sched[0].addr) * 4 + (cyc - sched[0].start)]);
      end else begin
        chk("rdata_idle", bmem_rdata, 64'd0);
      end

      // Advance the model across this cycle's clock edge.
      err_next = 0;
      if (wst == 0) begin
        if (bmem_write && exp_ready) begin
          mm[midx(bmem_addr) * 4] = bmem_wdata;
          widx = midx(bmem_addr);
          wst  = 1;
          if (bmem_read) err_next = 1;
        end else if (bmem_read && exp_ready) begin
          int st;
          st = (cyc + LAT > last_b3 + LAT) ? cyc + LAT : last_b3 + LAT;
          sched.push_back('{acc: cyc, pop: st - LAT + 1, start: st, addr: bmem_addr});
          last_b3 = st + 3;
        end
      end else begin
        if (bmem_write) begin
          mm[widx * 4 + wst] = bmem_wdata;
          wst = (wst == 3) ? 0 : wst + 1;
        end else begin
          wst      = 0;
          err_next = 1;
        end
      end
      err_exp = err_next;
      alive   = 1;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bmem_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bmem_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0, expected 1 within 100 cycles");
    end
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [63:0] d [4], input int nb, input bit with_rd);
    wait_ready();
    for (int k = 0; k < nb; k++) begin
      bmem_write = 1'b1;
      bmem_addr  = (k == 0) ? a : $urandom;
      bmem_wdata = d[k];
      bmem_read  = (k == 0) ? with_rd : ($urandom_range(0, 3) == 0);
      tick();
    end
    bmem_write = 1'b0;
    bmem_read  = 1'b0;
    bmem_wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a);
    wait_ready();
    bmem_read = 1'b1;
    bmem_addr = a;
    tick();
    bmem_read = 1'b0;
  endtask

  // After a read issued in cycle T, check cycles T+1..T+7 against literals.
  task automatic check_lit_burst(input string nm, input logic [31:0] ra, input logic [63:0] d [4]);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        chk({nm, "_rvalid"}, 64'(bmem_rvalid), 64'd1);
        chk({nm, "_rdata"}, bmem_rdata, d[i-LAT]);
        chk({nm, "_raddr"}, 64'(bmem_raddr), 64'(ra));
      end else begin
        chk({nm, "_early"}, 64'(bmem_rvalid), 64'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d [4];
    logic [63:0] lit [4];

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    for (int l = 0; l < LINES; l++) begin
      for (int k = 0; k < 4; k++) d[k] = {32'hC0DE_0000 | 32'(l << 4) | 32'(k), 32'h5A5A_0000 | 32'(l)};
      wr_burst(32'(l) << 5, d, 4, 0);
    end

    lit = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wr_burst(32'h0000_0040, lit, 4, 0);
    repeat (2) tick();
    rd(32'h0000_0040);
    check_lit_burst("basic", 32'h0000_0040, lit);
    repeat (5) tick();

    for (int i = 1; i <= 5; i++) begin
      bmem_read = 1'b1;
      bmem_addr = 32'(i) << 5;
      tick();
    end
    bmem_read = 1'b0;
    @(negedge clk);
    chk("queue_full_ready", 64'(bmem_ready), 64'd0);
    repeat (45) tick();

    for (int k = 0; k < 4; k++) d[k] = {32'hABCD_0000 | 32'(k), 32'h1234_5678};
    wr_burst(32'h0000_0060, d, 2, 0);
    @(negedge clk);
    chk("abort_err_same", 64'(proto_err), 64'd0);
    tick();
    @(negedge clk);
    chk("abort_err_next", 64'(proto_err), 64'd1);
    tick();
    rd(32'h0000_0060);
    repeat (10) tick();

    for (int k = 0; k < 4; k++) d[k] = {32'hFEED_0000 | 32'(k), 32'hBEEF_0000};
    wr_burst(32'h0000_00A0, d, 4, 1);
    repeat (15) tick();

    lit = '{64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
            64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4};
    wr_burst(32'h0000_0220, lit, 4, 0);
    repeat (2) tick();
    rd(32'h8000_0230);
    check_lit_burst("alias", 32'h8000_0220, lit);
    rd(32'h8000_0200);
    repeat (10) tick();

    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0, 1: rd($urandom);
        2: begin
          bmem_read = 1'b1;
          bmem_addr = $urandom;
          tick();
          bmem_read = 1'b0;
        end
        3: wr_burst($urandom, d, 4, 0);
        4: wr_burst($urandom, d, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        default: repeat ($urandom_range(1, 6)) tick();
      endcase
    end
    repeat (40) tick();

    bmem_read = 1'b1;
    bmem_addr = 32'h0000_01E0;
    tick();
    bmem_addr = 32'h0000_0040;
    tick();
    bmem_addr = 32'h0000_0080;
    tick();
    bmem_read = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ready", 64'(bmem_ready), 64'd0);
    chk("async_rst_rvalid", 64'(bmem_rvalid), 64'd0);
    chk("async_rst_rdata", bmem_rdata, 64'd0);
    chk("async_rst_raddr", 64'(bmem_raddr), 64'd0);
    chk("async_rst_err", 64'(proto_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("post_rst_ready", 64'(bmem_ready), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
